// File: rtl/json_cmd_pkg.sv
// Shared constants and types for the JSON motor-command receiver.
// Holds the ASCII tokens of the frame grammar, key bits and the parser state set.
package json_cmd_pkg;

  localparam int SPEED_W = 11;
  localparam int ACC_W   = 10;

  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_NL     = 8'h0A;
  localparam logic [7:0] CH_T      = 8'h54;
  localparam logic [7:0] CH_L      = 8'h4C;
  localparam logic [7:0] CH_R      = 8'h52;

  // One-hot key identifiers, also used as bits of the key-seen mask.
  localparam logic [2:0] KEY_T = 3'b001;
  localparam logic [2:0] KEY_L = 3'b010;
  localparam logic [2:0] KEY_R = 3'b100;

  typedef enum logic [3:0] {
    ST_IDLE, ST_KQ1, ST_KEY, ST_KQ2, ST_COLON, ST_SIGN,
    ST_INT, ST_DOT, ST_FRAC1, ST_FRAC2, ST_SEP, ST_EOL
  } parse_state_t;

  function automatic logic [ACC_W-1:0] mul10_add(input logic [ACC_W-1:0] a,
                                                 input logic [3:0] d);
    return (a << 3) + (a << 1) + ACC_W'(d);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, byte/frame-error strobes.
// After a low stop bit it waits for the line to return high before hunting again.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_in,
  output logic [BITS_N-1:0] data_rx,
  output logic              byte_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (BITS_N > 1) ? $clog2(BITS_N) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BITS_N - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  rx_state_t        state;
  logic             rx_s1, rx_s2;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  // NOTE: every register here is written with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      idx        <= '0;
      data_rx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= uart_in;
      rx_s2      <= rx_s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s2) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            data_rx <= {rx_s2, data_rx[BITS_N-1:1]};
            if (idx == LAST) state <= RX_STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            byte_valid <= rx_s2;
            frame_err  <= !rx_s2;
            state      <= rx_s2 ? RX_IDLE : RX_BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BREAK: if (rx_s2) state <= RX_IDLE;
        default:  state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/json_cmd_rx.sv
// JSON motor-command receiver: parses {"T":n,"L":x.xx,"R":x.xx}\n lines from UART
// and strobes cmd_valid with the decoded command, or parse_error on a discarded frame.
module json_cmd_rx
  import json_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_FRAME    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      uart_in,
  output logic                      cmd_valid,
  output logic [7:0]                cmd_t,
  output logic signed [SPEED_W-1:0] speed_l,
  output logic signed [SPEED_W-1:0] speed_r,
  output logic                      parse_error,
  output logic                      frame_error
);

  localparam int CNT_W = $clog2(MAX_FRAME + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME);

  logic [7:0]         data_rx;
  logic               byte_valid, frame_err;
  parse_state_t       state;
  logic [2:0]         cur_key, seen, key_oh, seen_next;
  logic               neg;
  logic [ACC_W-1:0]   acc, scaled;
  logic [1:0]         ndig;
  logic [CNT_W-1:0]   byte_cnt;
  logic [7:0]         sh_t;
  logic [SPEED_W-1:0] sh_l, sh_r, num_val;
  logic               is_dig, is_sep, is_t, sep_bad, byte_err, num_end;
  logic [3:0]         dig;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .BITS_N(8)) u_uart_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_in    (uart_in),
    .data_rx    (data_rx),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign frame_error = frame_err;
  assign dig    = data_rx[3:0];
  assign is_dig = (data_rx >= 8'h30) && (data_rx <= 8'h39);
  assign is_sep = (data_rx == CH_COMMA) || (data_rx == CH_RBRACE);
  assign is_t   = (cur_key == KEY_T);
  assign seen_next = seen | cur_key;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    key_oh = '0;
    unique case (data_rx)
      CH_T:    key_oh = KEY_T;
      CH_L:    key_oh = KEY_L;
      CH_R:    key_oh = KEY_R;
      default: key_oh = '0;
    endcase

    // Bring the accumulated digits to hundredths; T is taken as a plain integer.
    scaled = acc;
    if (state == ST_INT && !is_t) scaled = mul10_add(mul10_add(acc, 4'd0), 4'd0);
    else if (state == ST_FRAC1)   scaled = mul10_add(acc, 4'd0);
    num_val = neg ? SPEED_W'(0) - SPEED_W'(scaled) : SPEED_W'(scaled);

    sep_bad = (is_t && scaled > ACC_W'(255)) ||
              (data_rx == CH_RBRACE && seen_next != 3'b111);
    num_end = is_sep && (state == ST_INT || state == ST_FRAC1 ||
                         state == ST_FRAC2 || state == ST_SEP);

    byte_err = 1'b0;
    if (state != ST_IDLE) begin
      if (byte_cnt >= MAX_CNT) byte_err = 1'b1;
      else begin
        unique case (state)
          ST_KQ1, ST_KQ2: byte_err = (data_rx != CH_QUOTE);
          ST_KEY:         byte_err = (key_oh == '0) || ((seen & key_oh) != '0);
          ST_COLON:       byte_err = (data_rx != CH_COLON);
          ST_SIGN:        byte_err = (data_rx == CH_MINUS) ? (neg || is_t) : !is_dig;
          ST_INT: begin
            if (is_dig)                 byte_err = !is_t;
            else if (data_rx == CH_DOT) byte_err = is_t;
            else if (is_sep)            byte_err = sep_bad;
            else                        byte_err = 1'b1;
          end
          ST_DOT:         byte_err = !is_dig;
          ST_FRAC1:       byte_err = is_dig ? 1'b0 : (is_sep ? sep_bad : 1'b1);
          ST_FRAC2, ST_SEP: byte_err = is_sep ? sep_bad : 1'b1;
          ST_EOL:         byte_err = (data_rx != CH_NL);
          default:        byte_err = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_key     <= '0;
      seen        <= '0;
      neg         <= 1'b0;
      acc         <= '0;
      ndig        <= '0;
      byte_cnt    <= '0;
      sh_t        <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
      cmd_valid   <= 1'b0;
      cmd_t       <= '0;
      speed_l     <= '0;
      speed_r     <= '0;
      parse_error <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      parse_error <= 1'b0;
      if (frame_err) begin
        if (state != ST_IDLE) begin
          parse_error <= 1'b1;
          state       <= ST_IDLE;
        end
      end else if (byte_valid) begin
        if (byte_err) begin
          parse_error <= 1'b1;
          if (data_rx == CH_LBRACE) begin
            state    <= ST_KQ1;
            seen     <= '0;
            byte_cnt <= CNT_W'(1);
          end else begin
            state <= ST_IDLE;
          end
        end else begin
          if (state != ST_IDLE) byte_cnt <= byte_cnt + 1'b1;
          unique case (state)
            ST_IDLE: if (data_rx == CH_LBRACE) begin
              state    <= ST_KQ1;
              seen     <= '0;
              byte_cnt <= CNT_W'(1);
            end
            ST_KQ1:   state <= ST_KEY;
            ST_KEY: begin
              cur_key <= key_oh;
              state   <= ST_KQ2;
            end
            ST_KQ2:   state <= ST_COLON;
            ST_COLON: begin
              neg   <= 1'b0;
              acc   <= '0;
              state <= ST_SIGN;
            end
            ST_SIGN: begin
              if (data_rx == CH_MINUS) neg <= 1'b1;
              else begin
                acc   <= ACC_W'(dig);
                ndig  <= 2'd1;
                state <= ST_INT;
              end
            end
            ST_INT: begin
              if (is_dig) begin
                acc  <= mul10_add(acc, dig);
                ndig <= ndig + 1'b1;
                if (ndig == 2'd2) state <= ST_SEP;
              end else if (data_rx == CH_DOT) begin
                state <= ST_DOT;
              end
            end
            ST_DOT: begin
              acc   <= mul10_add(acc, dig);
              state <= ST_FRAC1;
            end
            ST_FRAC1: if (is_dig) begin
              acc   <= mul10_add(acc, dig);
              state <= ST_FRAC2;
            end
            ST_EOL: begin
              cmd_valid <= 1'b1;
              cmd_t     <= sh_t;
              speed_l   <= sh_l;
              speed_r   <= sh_r;
              state     <= ST_IDLE;
            end
            default: ;
          endcase
          if (num_end) begin
            seen <= seen_next;
            if (cur_key == KEY_T) sh_t <= scaled[7:0];
            if (cur_key == KEY_L) sh_l <= num_val;
            if (cur_key == KEY_R) sh_r <= num_val;
            state <= (data_rx == CH_COMMA) ? ST_KQ1 : ST_EOL;
          end
        end
      end
    end
  end

endmodule
